// File: rtl/regn_row_pkg.sv
// Shared definitions for the Tetris board-row register: operation encodings.
package regn_row_pkg;
    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_HOLD  = 3'b000;
    localparam logic [OP_W-1:0] OP_LOAD  = 3'b001;
    localparam logic [OP_W-1:0] OP_MERGE = 3'b010;
    localparam logic [OP_W-1:0] OP_CLEAR = 3'b011;
    localparam logic [OP_W-1:0] OP_SHL   = 3'b100;
    localparam logic [OP_W-1:0] OP_SHR   = 3'b101;
endpackage

// File: rtl/regn_row_cell.sv
// One cell of a board row: next-value mux feeding an enabled flop with sync reset.
import regn_row_pkg::*;

module regn_row_cell (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_en,
    input  logic [OP_W-1:0] i_op,
    input  logic            i_load,
    input  logic            i_merge_ok,
    input  logic            i_shl_src,
    input  logic            i_shr_src,
    output logic            o_q
);
    logic r_q;
    logic w_next;

    always_comb begin
        w_next = r_q;
        case (i_op)
            OP_LOAD:  w_next = i_load;
            OP_MERGE: w_next = i_merge_ok ? (r_q | i_load) : r_q;
            OP_CLEAR: w_next = 1'b0;
            OP_SHL:   w_next = i_shl_src;
            OP_SHR:   w_next = i_shr_src;
            default:  w_next = r_q;  // HOLD and reserved codes
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_q <= 1'b0;
        else if (i_en)
            r_q <= w_next;
    end

    assign o_q = r_q;
endmodule

// File: rtl/regn_row.sv
// WIDTH-bit Tetris row register with load/merge/clear/shift, flags and popcount.
// Define REGN_ROW_ROTATE_EN to make shifts rotate instead of filling from serialIn.
import regn_row_pkg::*;

module regn_row #(
    parameter  int WIDTH = 10,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inEnabled,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] in,
    input  logic             serialIn,
    output logic [WIDTH-1:0] out,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             collide,
    output logic             shiftOut
);
    logic             w_overlap;
    logic             w_fill_shl;
    logic             w_fill_shr;
    logic [CW-1:0]    w_count;
    logic             r_collide;
    logic             r_shift_out;

    assign w_overlap = |(out & in);

`ifdef REGN_ROW_ROTATE_EN
    assign w_fill_shl = out[WIDTH-1];
    assign w_fill_shr = out[0];
`else
    assign w_fill_shl = serialIn;
    assign w_fill_shr = serialIn;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic w_shl_src;
        logic w_shr_src;
        // SHL pulls from the lower neighbour, SHR from the upper one.
        if (i == 0) begin : g_lo
            assign w_shl_src = w_fill_shl;
        end else begin : g_lo_n
            assign w_shl_src = out[i-1];
        end
        if (i == WIDTH - 1) begin : g_hi
            assign w_shr_src = w_fill_shr;
        end else begin : g_hi_n
            assign w_shr_src = out[i+1];
        end

        regn_row_cell u_cell (
            .i_clk      (clk),
            .i_reset    (reset),
            .i_en       (inEnabled),
            .i_op       (op),
            .i_load     (in[i]),
            .i_merge_ok (~w_overlap),
            .i_shl_src  (w_shl_src),
            .i_shr_src  (w_shr_src),
            .o_q        (out[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_collide   <= 1'b0;
            r_shift_out <= 1'b0;
        end else begin
            r_collide <= inEnabled && (op == OP_MERGE) && w_overlap;
            if (inEnabled && op == OP_SHL)
                r_shift_out <= out[WIDTH-1];
            else if (inEnabled && op == OP_SHR)
                r_shift_out <= out[0];
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < WIDTH; i++)
            w_count = w_count + CW'(out[i]);
    end

    assign count    = w_count;
    assign full     = &out;
    assign empty    = ~|out;
    assign collide  = r_collide;
    assign shiftOut = r_shift_out;
endmodule
